// File: rtl/ssp_uart_host.sv
// SSP-side initiator for the UART register-access port.
// Each accepted command becomes one timed frame: SETUP, then 4 header bits,
// then 12 data bits (SCK low then high in each bit), then an inter-frame gap.
// The read value is captured at the end of bit 0 and returned with a
// one-cycle strobe. All outputs come straight from flops.
module ssp_uart_host #(
    parameter int pDiv = 2,
    parameter int pGap = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    output logic        Rdy,
    input  logic [2:0]  Cmd_RA,
    input  logic        Cmd_WnR,
    input  logic [11:0] Cmd_WD,
    output logic        Rsp_Vld,
    output logic [11:0] Rsp_RD,
    output logic        SSP_SSEL,
    output logic        SSP_SCK,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic        SSP_En,
    output logic        SSP_EOC,
    output logic [11:0] SSP_DI,
    input  logic [11:0] SSP_DO
);

    localparam int DW = $clog2(pDiv) + 1;
    localparam int GW = $clog2(pGap) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(pDiv - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(pGap - 1);
    // Bit counter spans header and data: 15..12 are header bits, 11..0 data.
    localparam logic [4:0] BIT_FIRST = 5'd15;
    localparam logic [4:0] BIT_HDR_LAST = 5'd12;

    typedef enum logic [2:0] {IDLE, SETUP, HDR, DATA, GAP} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          ph_q, ph_d;
    logic [4:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;

    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic [11:0]   rd_q, rd_d;
    logic          ssel_q, ssel_d;
    logic          sck_q, sck_d;
    logic [2:0]    ra_q, ra_d;
    logic          wnr_q, wnr_d;
    logic          en_q, en_d;
    logic          eoc_q, eoc_d;
    logic [11:0]   di_q, di_d;

    logic          half_end;

    // Next-state, counters, command latch and read capture.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        ra_d     = ra_q;
        wnr_d    = wnr_q;
        di_d     = di_q;
        rd_d     = rd_q;
        vld_d    = 1'b0;
        half_end = (div_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d = SETUP;
                    div_d   = '0;
                    ph_d    = 1'b0;
                    bit_d   = BIT_FIRST;
                    ra_d    = Cmd_RA;
                    wnr_d   = Cmd_WnR;
                    di_d    = Cmd_WnR ? Cmd_WD : 12'h000;
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_d = HDR;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            HDR, DATA: begin
                if (half_end) begin
                    div_d = '0;
                    ph_d  = ~ph_q;
                    // End of a high half closes the current bit.
                    if (ph_q) begin
                        if (bit_q == 5'd0) begin
                            state_d = GAP;
                            gap_d   = '0;
                            rd_d    = SSP_DO;
                            vld_d   = 1'b1;
                            ra_d    = 3'b000;
                            wnr_d   = 1'b0;
                            di_d    = 12'h000;
                        end else begin
                            bit_d = bit_q - 5'd1;
                            if (bit_q == BIT_HDR_LAST) state_d = DATA;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Port-level outputs derived from the next state so they are registered.
    always_comb begin
        rdy_d  = (state_d == IDLE);
        ssel_d = (state_d == SETUP) || (state_d == HDR) || (state_d == DATA);
        sck_d  = ((state_d == HDR) || (state_d == DATA)) && ph_d;
        en_d   = (state_d == DATA);
        eoc_d  = (state_d == DATA) && (bit_d == 5'd0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            ph_q    <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            rd_q    <= '0;
            ssel_q  <= 1'b0;
            sck_q   <= 1'b0;
            ra_q    <= '0;
            wnr_q   <= 1'b0;
            en_q    <= 1'b0;
            eoc_q   <= 1'b0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            ssel_q  <= ssel_d;
            sck_q   <= sck_d;
            ra_q    <= ra_d;
            wnr_q   <= wnr_d;
            en_q    <= en_d;
            eoc_q   <= eoc_d;
            di_q    <= di_d;
        end
    end

    assign Rdy      = rdy_q;
    assign Rsp_Vld  = vld_q;
    assign Rsp_RD   = rd_q;
    assign SSP_SSEL = ssel_q;
    assign SSP_SCK  = sck_q;
    assign SSP_RA   = ra_q;
    assign SSP_WnR  = wnr_q;
    assign SSP_En   = en_q;
    assign SSP_EOC  = eoc_q;
    assign SSP_DI   = di_q;

endmodule

// File: tb/tb_ssp_uart_host.sv
// Bench for ssp_uart_host: two instances (default timing and pDiv=1/pGap=1)
// driven with directed and random commands; every cycle of each frame is
// compared against a timing model derived from the frame rules.
module tb_ssp_uart_host;

    localparam int P0 = 2, G0 = 2, P1 = 1, G1 = 1;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst  [2];
    logic        req  [2];
    logic [2:0]  ra   [2];
    logic        wnr  [2];
    logic [11:0] wd   [2];
    logic [11:0] dout [2];
    logic        rdy  [2];
    logic        vld  [2];
    logic [11:0] rd   [2];
    logic        ssel [2];
    logic        sck  [2];
    logic [2:0]  sra  [2];
    logic        swnr [2];
    logic        en   [2];
    logic        eoc  [2];
    logic [11:0] di   [2];

    logic [11:0] last_rd [2];
    int errs = 0;
    int checks = 0;

    ssp_uart_host #(.pDiv(P0), .pGap(G0)) u0 (
        .Clk(Clk), .Rst(rst[0]), .Req(req[0]), .Rdy(rdy[0]),
        .Cmd_RA(ra[0]), .Cmd_WnR(wnr[0]), .Cmd_WD(wd[0]),
        .Rsp_Vld(vld[0]), .Rsp_RD(rd[0]),
        .SSP_SSEL(ssel[0]), .SSP_SCK(sck[0]), .SSP_RA(sra[0]), .SSP_WnR(swnr[0]),
        .SSP_En(en[0]), .SSP_EOC(eoc[0]), .SSP_DI(di[0]), .SSP_DO(dout[0]));

    ssp_uart_host #(.pDiv(P1), .pGap(G1)) u1 (
        .Clk(Clk), .Rst(rst[1]), .Req(req[1]), .Rdy(rdy[1]),
        .Cmd_RA(ra[1]), .Cmd_WnR(wnr[1]), .Cmd_WD(wd[1]),
        .Rsp_Vld(vld[1]), .Rsp_RD(rd[1]),
        .SSP_SSEL(ssel[1]), .SSP_SCK(sck[1]), .SSP_RA(sra[1]), .SSP_WnR(swnr[1]),
        .SSP_En(en[1]), .SSP_EOC(eoc[1]), .SSP_DI(di[1]), .SSP_DO(dout[1]));

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h (rdy,vld,rd,ssel,sck,ra,wnr,en,eoc,di)", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] obs(input int u);
        return {rdy[u], vld[u], rd[u], ssel[u], sck[u], sra[u], swnr[u], en[u], eoc[u], di[u]};
    endfunction

    // Expected outputs k cycles after acceptance, from the frame timing rules.
    function automatic logic [33:0] model(input int p, input int g, input int k,
                                          input logic [2:0] a, input logic w,
                                          input logic [11:0] d, input logic [11:0] rdv);
        int   last;
        logic e_ssel, e_sck, e_en, e_eoc, e_rdy, e_vld;
        last   = 33 * p;
        e_ssel = (k >= 1) && (k <= last);
        e_sck  = (k > p) && (k <= last) && ((((k - p - 1) / p) % 2) == 1);
        e_en   = (k > 9 * p) && (k <= last);
        e_eoc  = (k > 31 * p) && (k <= last);
        e_rdy  = (k > last + g);
        e_vld  = (k == last + 1);
        return {e_rdy, e_vld, rdv, e_ssel, e_sck, e_ssel ? a : 3'b000, e_ssel & w,
                e_en, e_eoc, (e_ssel && w) ? d : 12'h000};
    endfunction

    // One command on unit u. hold keeps Req high; busy_at pulses Req (with
    // scrambled command fields) mid-frame; rst_at asserts Rst at that cycle.
    task automatic frame(input int u, input logic [2:0] a, input logic w, input logic [11:0] d,
                         input logic [11:0] dov, input bit hold, input int busy_at,
                         input int rst_at, input string tag);
        int p, g, n;
        p = (u == 0) ? P0 : P1;
        g = (u == 0) ? G0 : G1;
        req[u] = 1'b1; ra[u] = a; wnr[u] = w; wd[u] = d;
        n = 0;
        while (!rdy[u] && n < 300) begin
            @(posedge Clk); #1; n++;
        end
        if (!rdy[u]) begin
            chk({tag, "_rdy_timeout"}, 34'(rdy[u]), 34'd1);
            req[u] = 1'b0;
            return;
        end
        @(posedge Clk); #1;
        if (!hold) req[u] = 1'b0;
        dout[u] = dov;
        for (int k = 1; k <= 33 * p + g + 1; k++) begin
            chk(tag, obs(u), model(p, g, k, a, w, d, (k > 33 * p) ? dov : last_rd[u]));
            if (k == rst_at) begin
                rst[u] = 1'b1;
                req[u] = 1'b0;
                @(posedge Clk); #1;
                rst[u] = 1'b0;
                last_rd[u] = 12'h000;
                chk({tag, "_rst"}, obs(u), {1'b1, 33'b0});
                return;
            end
            if (k == busy_at) begin
                req[u] = 1'b1; ra[u] = ~a; wnr[u] = ~w; wd[u] = ~d;
            end else if (busy_at != 0 && k == busy_at + 1) begin
                req[u] = 1'b0;
            end
            @(posedge Clk); #1;
        end
        last_rd[u] = dov;
    endtask

    task automatic idle(input int u, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            chk(tag, obs(u), {1'b1, 1'b0, last_rd[u], 20'b0});
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; ra[u] = '0; wnr[u] = 1'b0;
            wd[u] = '0; dout[u] = '0; last_rd[u] = '0;
        end
        @(posedge Clk); #1;
        chk("reset_u0", obs(0), {1'b1, 33'b0});
        chk("reset_u1", obs(1), {1'b1, 33'b0});
        @(posedge Clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle(0, 2, "idle0");

        // Default timing unit.
        frame(0, 3'b010, 1'b1, 12'hA5C, 12'h777, 1'b0, 0, 0, "write");
        frame(0, 3'b001, 1'b0, 12'hFFF, 12'h3F0, 1'b0, 0, 0, "read");
        idle(0, 3, "idle1");
        frame(0, 3'(($urandom)), 1'b1, 12'($urandom), 12'($urandom), 1'b1, 0, 0, "b2b_a");
        frame(0, 3'(($urandom)), 1'b0, 12'($urandom), 12'($urandom), 1'b0, 0, 0, "b2b_b");
        frame(0, 3'b110, 1'b1, 12'h123, 12'h456, 1'b0, 20, 0, "busy");
        idle(0, 80, "busy_idle");
        frame(0, 3'b011, 1'b1, 12'hBEE, 12'hCAF, 1'b0, 0, 30, "midrst");
        idle(0, 2, "post_rst_idle");
        frame(0, 3'b101, 1'b1, 12'h0F0, 12'h00F, 1'b0, 0, 0, "post_rst");
        for (int i = 0; i < 6; i++) begin
            frame(0, 3'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
                  (i < 5) ? 1'($urandom) : 1'b0, 0, 0, "rand0");
        end
        idle(0, 3, "idle2");

        // Fast unit: pDiv=1, pGap=1.
        frame(1, 3'b010, 1'b1, 12'hA5C, 12'h5A5, 1'b0, 0, 0, "fast_write");
        frame(1, 3'b001, 1'b0, 12'h0FF, 12'h3F0, 1'b1, 0, 0, "fast_b2b_a");
        frame(1, 3'b111, 1'b1, 12'h800, 12'h001, 1'b0, 0, 0, "fast_b2b_b");
        for (int i = 0; i < 5; i++) begin
            frame(1, 3'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
                  (i < 4) ? 1'($urandom) : 1'b0, 0, 0, "rand1");
        end
        idle(1, 3, "idle3");
        idle(0, 1, "idle4");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
